// File: rtl/ipsmacge_pfc_pkg.sv
// Shared constants for the per-class pause engine: FSM codes, default widths, stat helper.
package ipsmacge_pfc_pkg;

  localparam int unsigned PfcNcls  = 8;
  localparam int unsigned PfcQw    = 16;
  localparam int unsigned PfcSlotw = 6;
  localparam int unsigned PfcStatW = 16;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StReq  = 1'b1;

  // Saturating increment for the optional Rx load counters.
  function automatic logic [PfcStatW-1:0] sat_inc(input logic [PfcStatW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ipsmacge_pfc_if.sv
// Request/ack bus between the pause engine (master) and Txframing (slave).
interface ipsmacge_pfc_if import ipsmacge_pfc_pkg::*; #(
  parameter int unsigned NCLS = PfcNcls
) ();

  logic            pau_oen;
  logic [NCLS-1:0] pau_vec;
  logic [NCLS-1:0] pau_off;
  logic            pau_ack;

  modport master (output pau_oen, output pau_vec, output pau_off, input pau_ack);
  modport slave  (input pau_oen, input pau_vec, input pau_off, output pau_ack);

endinterface

// File: rtl/ipsmacge_pfc_tmr.sv
// One Rx pause timer: clear beats load, load beats decrement; busy while nonzero.
module ipsmacge_pfc_tmr import ipsmacge_pfc_pkg::*; #(
  parameter int unsigned QW = PfcQw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [QW-1:0] qua_i,
  input  logic          dec_i,
  output logic          busy_o
);

  logic [QW-1:0] tmr_d, tmr_q;

  // Next timer value.
  always_comb begin
    tmr_d = tmr_q;
    if (clr_i) begin
      tmr_d = '0;
    end else if (load_i) begin
      tmr_d = qua_i;
    end else if (dec_i && (tmr_q != '0)) begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  // Timer state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmr_q <= '0;
    else         tmr_q <= tmr_d;
  end

  assign busy_o = |tmr_q;

endmodule

// File: rtl/ipsmacge_pfc.sv
// Per-class pause engine for the GE MAC Tx path.
// Optional IPSMACGE_PFC_STAT_EN adds rx_pfccnt, per-class saturating count of Rx timer loads.
module ipsmacge_pfc import ipsmacge_pfc_pkg::*; #(
  parameter int unsigned NCLS  = PfcNcls,
  parameter int unsigned QW    = PfcQw,
  parameter int unsigned SLOTW = PfcSlotw
) (
  input  logic               txclk,
  input  logic               txrst_,
  input  logic               upact,
  input  logic               uppaudis,
  input  logic               rx_pauvld,
  input  logic [NCLS-1:0]    rx_pauvec,
  input  logic [NCLS*QW-1:0] rx_pauqua,
  input  logic               pau_ival,
  output logic [NCLS-1:0]    pau_trandis,
  input  logic [NCLS-1:0]    pause_en,
  input  logic [QW-1:0]      iquanta,
  ipsmacge_pfc_if.master     pau_if
`ifdef IPSMACGE_PFC_STAT_EN
  ,
  output logic [NCLS*PfcStatW-1:0] rx_pfccnt
`endif
);

  logic            vld_m_d, vld_m_q, vld_s1_d, vld_s1_q, vld_s2_d, vld_s2_q;
  logic [NCLS-1:0] pe_m_d, pe_m_q, pe_s1_d, pe_s1_q, pe_s2_d, pe_s2_q;
  logic [SLOTW-1:0] slot_d, slot_q;
  logic [QW-1:0]   gq_d, gq_q;
  logic [NCLS-1:0] pend_on_d, pend_on_q, pend_off_d, pend_off_q;
  logic [NCLS-1:0] vec_d, vec_q, off_d, off_q, pend_clr;
  logic [0:0]      state_d, state_q;
  logic            rcvvld, qtumena, gensample, latch, tmr_clr;
  logic [NCLS-1:0] pe_start, pe_stop;

  // Synchroniser chains; third stage only serves edge detection.
  always_comb begin
    vld_m_d  = rx_pauvld;
    vld_s1_d = vld_m_q;
    vld_s2_d = vld_s1_q;
    pe_m_d   = pause_en;
    pe_s1_d  = pe_m_q;
    pe_s2_d  = pe_s1_q;
    if (!upact) begin
      {vld_m_d, vld_s1_d, vld_s2_d} = '0;
      pe_m_d  = '0;
      pe_s1_d = '0;
      pe_s2_d = '0;
    end
  end

  assign rcvvld    = vld_s1_q & ~vld_s2_q;
  assign pe_start  = pe_s1_q & ~pe_s2_q;
  assign pe_stop   = ~pe_s1_q & pe_s2_q;
  assign qtumena   = (&slot_q) & pau_ival;
  assign gensample = qtumena & (gq_q >= iquanta) & (|iquanta);
  assign latch     = (state_q == StIdle) & (|(pend_on_q | pend_off_q)) & ~uppaudis;
  assign pend_clr  = latch ? (pend_on_q | pend_off_q) : '0;
  assign tmr_clr   = ~upact | uppaudis;

  // Slot counter, refresh counter and pending request bits.
  always_comb begin
    slot_d = pau_ival ? slot_q + 1'b1 : slot_q;
    if (tmr_clr) slot_d = '0;

    gq_d = gq_q;
    if (!upact || !(|pe_s1_q) || gensample) gq_d = '0;
    else if (qtumena && !(&gq_q))           gq_d = gq_q + 1'b1;

    // Bits latched into a frame clear; events of the same cycle survive.
    pend_on_d  = (pend_on_q & ~pend_clr & ~pe_stop) | pe_start | ({NCLS{gensample}} & pe_s1_q);
    pend_off_d = (pend_off_q & ~pend_clr & ~pe_start) | pe_stop;
    if (tmr_clr) begin
      pend_on_d  = '0;
      pend_off_d = '0;
    end
  end

  // Request FSM; vec/off frozen while a request is outstanding.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    off_d   = off_q;
    if (!upact) begin
      state_d = StIdle;
      vec_d   = '0;
      off_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (latch) begin
            state_d = StReq;
            vec_d   = pend_on_q | pend_off_q;
            off_d   = pend_off_q;
          end
        end
        default: begin
          if (pau_if.pau_ack) state_d = StIdle;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      {vld_m_q, vld_s1_q, vld_s2_q} <= '0;
      pe_m_q     <= '0;
      pe_s1_q    <= '0;
      pe_s2_q    <= '0;
      slot_q     <= '0;
      gq_q       <= '0;
      pend_on_q  <= '0;
      pend_off_q <= '0;
      state_q    <= StIdle;
      vec_q      <= '0;
      off_q      <= '0;
    end else begin
      {vld_m_q, vld_s1_q, vld_s2_q} <= {vld_m_d, vld_s1_d, vld_s2_d};
      pe_m_q     <= pe_m_d;
      pe_s1_q    <= pe_s1_d;
      pe_s2_q    <= pe_s2_d;
      slot_q     <= slot_d;
      gq_q       <= gq_d;
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      state_q    <= state_d;
      vec_q      <= vec_d;
      off_q      <= off_d;
    end
  end

  assign pau_if.pau_oen = (state_q == StReq);
  assign pau_if.pau_vec = vec_q;
  assign pau_if.pau_off = off_q;

  for (genvar i = 0; i < NCLS; i++) begin : g_tmr
    ipsmacge_pfc_tmr #(.QW(QW)) u_tmr (
      .clk_i  (txclk),
      .rst_ni (txrst_),
      .clr_i  (tmr_clr),
      .load_i (rcvvld & rx_pauvec[i]),
      .qua_i  (rx_pauqua[i*QW +: QW]),
      .dec_i  (qtumena),
      .busy_o (pau_trandis[i])
    );
  end

`ifdef IPSMACGE_PFC_STAT_EN
  logic [NCLS-1:0][PfcStatW-1:0] cnt_d, cnt_q;

  // Count effective Rx loads; only port deactivation clears.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NCLS; i++) begin
      if (!upact)                                     cnt_d[i] = '0;
      else if (rcvvld && rx_pauvec[i] && !uppaudis)   cnt_d[i] = sat_inc(cnt_q[i]);
    end
  end

  // Stat counter state.
  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign rx_pfccnt = cnt_q;
`endif

endmodule

// File: tb/tb_ipsmacge_pfc.sv
// Randomised and directed bench for ipsmacge_pfc against a behavioural model.
module tb_ipsmacge_pfc;

  logic         txclk = 1'b0;
  logic         txrst_ = 1'b0;
  logic         upact = 1'b0, uppaudis = 1'b0, rx_pauvld = 1'b0, pau_ival = 1'b0;
  logic [7:0]   rx_pauvec = '0, pause_en = '0, pau_trandis;
  logic [127:0] rx_pauqua = '0;
  logic [15:0]  iquanta = '0;
`ifdef IPSMACGE_PFC_STAT_EN
  logic [127:0] rx_pfccnt;
`endif

  ipsmacge_pfc_if #(.NCLS(8)) pau_if ();

  ipsmacge_pfc #(.NCLS(8), .QW(16), .SLOTW(6)) dut (
    .txclk       (txclk),
    .txrst_      (txrst_),
    .upact       (upact),
    .uppaudis    (uppaudis),
    .rx_pauvld   (rx_pauvld),
    .rx_pauvec   (rx_pauvec),
    .rx_pauqua   (rx_pauqua),
    .pau_ival    (pau_ival),
    .pau_trandis (pau_trandis),
    .pause_en    (pause_en),
    .iquanta     (iquanta),
    .pau_if      (pau_if.master)
`ifdef IPSMACGE_PFC_STAT_EN
    ,
    .rx_pfccnt   (rx_pfccnt)
`endif
  );

  always #5 txclk = ~txclk;

  int n_chk = 0, n_err = 0;
  int ack_auto = 0, ack_cnt = 0, ack_wait = 0;

  // Behavioural model: delay lines, integer timers, pending sets, one request slot.
  bit       m_vld[3];
  bit [7:0] m_pe[3];
  int       m_tmr[8];
  int       m_slot, m_gq;
  bit [7:0] m_on, m_off, m_vec, m_offv;
  bit       m_req;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_trandis();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (m_tmr[i] != 0);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin m_vld[i] = 0; m_pe[i] = '0; end
    for (int i = 0; i < 8; i++) m_tmr[i] = 0;
    m_slot = 0; m_gq = 0; m_on = '0; m_off = '0; m_vec = '0; m_offv = '0; m_req = 0;
  endtask

  task automatic model_tick();
    bit [7:0] syn, start, stop, taken, refresh;
    bit       frame, quantum, sample, send;
    if (!txrst_ || !upact) begin model_clear(); return; end
    frame   = m_vld[1] && !m_vld[2];
    syn     = m_pe[1];
    start   = m_pe[1] & ~m_pe[2];
    stop    = ~m_pe[1] & m_pe[2];
    quantum = pau_ival && (m_slot == 63);
    sample  = quantum && (iquanta != 0) && (m_gq >= int'(iquanta));
    refresh = sample ? syn : 8'h00;
    send    = !m_req && ((m_on | m_off) != 0) && !uppaudis;
    taken   = send ? (m_on | m_off) : 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (uppaudis)                      m_tmr[i] = 0;
      else if (frame && rx_pauvec[i])    m_tmr[i] = int'(rx_pauqua[i*16 +: 16]);
      else if (quantum && m_tmr[i] > 0)  m_tmr[i] = m_tmr[i] - 1;
    end
    if (uppaudis)      m_slot = 0;
    else if (pau_ival) m_slot = (m_slot + 1) % 64;
    if (syn == 0 || sample) m_gq = 0;
    else if (quantum)       m_gq = (m_gq >= 65535) ? 65535 : m_gq + 1;
    if (send) begin
      m_req = 1; m_vec = m_on | m_off; m_offv = m_off;
    end else if (m_req && pau_if.pau_ack) begin
      m_req = 0;
    end
    if (uppaudis) begin
      m_on = '0; m_off = '0;
    end else begin
      m_on  = (m_on & ~taken & ~stop) | start | refresh;
      m_off = (m_off & ~taken & ~start) | stop;
    end
    m_vld[2] = m_vld[1]; m_vld[1] = m_vld[0]; m_vld[0] = rx_pauvld;
    m_pe[2]  = m_pe[1];  m_pe[1]  = m_pe[0];  m_pe[0]  = pause_en;
  endtask

  task automatic drive_ack();
    if (pau_if.pau_ack) begin
      pau_if.pau_ack = 1'b0;
    end else if (m_req) begin
      if (ack_cnt >= ack_wait) begin
        pau_if.pau_ack = 1'b1; ack_cnt = 0; ack_wait = $urandom_range(0, 5);
      end else ack_cnt++;
    end else begin
      ack_cnt = 0;
      if ($urandom_range(0, 63) == 0) pau_if.pau_ack = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge txclk);
    model_tick();
    #1;
    check("cycle", 64'({pau_trandis, pau_if.pau_oen, pau_if.pau_vec, pau_if.pau_off}),
          64'({m_trandis(), m_req, m_vec, m_offv}));
    if (ack_auto != 0) drive_ack();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_oen(input string tag, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (pau_if.pau_oen) break;
      step();
    end
    check(tag, 64'(pau_if.pau_oen), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (!pau_if.pau_oen) break;
      step();
    end
    check(tag, 64'(pau_if.pau_oen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c2, n, nfr, fr_cnt, dis_cnt, act_cnt;
    logic [7:0] other, acc;
    logic prev;
    pau_if.pau_ack = 1'b0;
    model_clear();
    steps(3);
    check("reset_out", 64'({pau_trandis, pau_if.pau_oen, pau_if.pau_vec, pau_if.pau_off}), 64'd0);
    txrst_ = 1'b1;
    upact = 1'b1;

    // Idle port stays quiet.
    acc = '0;
    for (int k = 0; k < 1000; k++) begin
      step();
      acc |= pau_trandis | pau_if.pau_vec | pau_if.pau_off | {7'd0, pau_if.pau_oen};
    end
    check("idle_quiet", 64'(acc), 64'd0);

    // Classes 0 and 2 paused for 3 and 1 quanta.
    rx_pauvec = 8'h05; rx_pauqua = '0; rx_pauqua[15:0] = 16'd3; rx_pauqua[47:32] = 16'd1;
    pau_ival = 1'b1; rx_pauvld = 1'b1;
    c0 = 0; c2 = 0; other = '0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (k == 5) rx_pauvld = 1'b0;
      c0 += int'(pau_trandis[0]);
      c2 += int'(pau_trandis[2]);
      other |= pau_trandis & 8'hfa;
      if (k > 10 && pau_trandis == 8'h00) break;
    end
    check("cls0_len", 64'(c0 >= 129 && c0 <= 192), 64'd1);
    check("cls2_len", 64'(c2 >= 1 && c2 <= 64), 64'd1);
    check("cls_others", 64'(other), 64'd0);

    // Zero quanta releases a class three cycles after the frame edge.
    rx_pauvec = 8'h01; rx_pauqua[15:0] = 16'd3; rx_pauvld = 1'b1;
    steps(5); rx_pauvld = 1'b0; steps(100);
    check("reload_busy", 64'(pau_trandis[0]), 64'd1);
    rx_pauqua[15:0] = 16'd0; rx_pauvld = 1'b1; n = 0;
    for (int k = 0; k < 10; k++) begin
      step(); n++;
      if (!pau_trandis[0]) break;
    end
    check("reload_lat", 64'(n), 64'd3);
    rx_pauvld = 1'b0; steps(4);

    // XOFF request held without ack, then XON follows.
    pause_en[3] = 1'b1;
    wait_oen("xoff_req", 20);
    check("xoff_vec", 64'({pau_if.pau_vec, pau_if.pau_off}), 64'h0800);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 2) pause_en[3] = 1'b0;
      check("xoff_hold", 64'({pau_if.pau_oen, pau_if.pau_vec, pau_if.pau_off}), 64'h10800);
    end
    pau_if.pau_ack = 1'b1; step(); pau_if.pau_ack = 1'b0;
    check("xoff_drop", 64'(pau_if.pau_oen), 64'd0);
    wait_oen("xon_req", 10);
    check("xon_vec", 64'({pau_if.pau_vec, pau_if.pau_off}), 64'h0808);
    pau_if.pau_ack = 1'b1; step(); pau_if.pau_ack = 1'b0; steps(3);

    // Periodic refresh of classes 0 and 7.
    ack_auto = 1; iquanta = 16'd2; pause_en = 8'h81; nfr = 0; prev = 1'b0;
    for (int k = 0; k < 1200 && nfr < 4; k++) begin
      step();
      if (pau_if.pau_oen && !prev) begin
        nfr++;
        check("refresh_vec", 64'({pau_if.pau_vec, pau_if.pau_off}), 64'h8100);
      end
      prev = pau_if.pau_oen;
    end
    check("refresh_cnt", 64'(nfr), 64'd4);
    pau_ival = 1'b0;
    wait_idle("refresh_idle", 20);
    pause_en = 8'h00;
    wait_oen("xon2_req", 20);
    check("xon2_vec", 64'({pau_if.pau_vec, pau_if.pau_off}), 64'h8181);
    wait_idle("xon2_idle", 20);
    ack_auto = 0; pau_if.pau_ack = 1'b0; iquanta = 16'd0; pau_ival = 1'b1; steps(3);

    // Port deactivation during a request.
    rx_pauvec = 8'hff;
    for (int i = 0; i < 8; i++) rx_pauqua[i*16 +: 16] = 16'd5;
    rx_pauvld = 1'b1; steps(5); rx_pauvld = 1'b0; steps(3);
    pause_en = 8'h02;
    wait_oen("deact_req", 20);
    upact = 1'b0; step();
    check("deact_oen", 64'(pau_if.pau_oen), 64'd0);
    check("deact_vec", 64'({pau_if.pau_vec, pau_if.pau_off}), 64'd0);
    check("deact_tmr", 64'(pau_trandis), 64'd0);
    pause_en = 8'h00; steps(2); upact = 1'b1; steps(3);
    pau_if.pau_ack = 1'b1; step(); pau_if.pau_ack = 1'b0;
    acc = '0;
    for (int k = 0; k < 10; k++) begin step(); acc[0] = acc[0] | pau_if.pau_oen; end
    check("late_ack", 64'(acc[0]), 64'd0);

    // Random traffic.
    ack_auto = 1; fr_cnt = 0; dis_cnt = 0; act_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      int b;
      pau_ival = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        b = $urandom_range(0, 7);
        pause_en[b] = ~pause_en[b];
      end
      if (dis_cnt > 0) dis_cnt--;
      else if ($urandom_range(0, 299) == 0) dis_cnt = $urandom_range(1, 4);
      uppaudis = (dis_cnt > 0);
      if (act_cnt > 0) act_cnt--;
      else if ($urandom_range(0, 799) == 0) act_cnt = $urandom_range(1, 3);
      upact = (act_cnt == 0);
      if ($urandom_range(0, 199) == 0) iquanta = 16'($urandom_range(0, 3));
      if (fr_cnt > 0) begin
        fr_cnt--;
        if (fr_cnt == 4) rx_pauvld = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        rx_pauvec = 8'($urandom);
        for (int i = 0; i < 8; i++) rx_pauqua[i*16 +: 16] = 16'($urandom_range(0, 3));
        rx_pauvld = 1'b1; fr_cnt = 9;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
